// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a two-flop input synchroniser, mid-bit sampling and a framing-error flag.
//   i_Clock        system clock, all logic on posedge
//   i_Reset_n      asynchronous active-low reset
//   i_Rx_Serial    asynchronous serial line, idles high
//   o_Rx_DV        one-cycle pulse, o_Rx_Byte holds a newly received good byte
//   o_Rx_Byte      last correctly framed byte, held until the next good frame
//   o_Rx_Active    high while a frame is being received (START through STOP)
//   o_Rx_Frame_Err one-cycle pulse, stop bit sampled low
module uart_rx #(
    parameter int CLKS_PER_BIT = -1
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err
);
    localparam int CNT_SIZE = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_SIZE-1:0] HALF = CNT_SIZE'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_SIZE-1:0] LAST = CNT_SIZE'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

    state_t              state_q, state_d;
    logic [CNT_SIZE-1:0] cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          data_q, data_d;
    logic [7:0]          byte_q, byte_d;
    logic                dv_q, dv_d;
    logic                err_q, err_d;
    logic                active_q, active_d;
    logic                rx_meta_q, rx_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        err_d    = 1'b0;
        active_d = active_q;
        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                idx_d    = '0;
                active_d = 1'b0;
                if (!rx_q) begin
                    state_d  = START;
                    active_d = 1'b1;
                end
            end
            START: begin
                // Re-check the line at mid start bit so a short glitch is not taken as a frame.
                if (cnt_q == HALF) begin
                    cnt_d    = '0;
                    state_d  = rx_q ? IDLE : DATA;
                    active_d = !rx_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d         = '0;
                    data_d[idx_q] = rx_q;
                    idx_d         = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d    = '0;
                    active_d = 1'b0;
                    state_d  = CLEANUP;
                    byte_d   = rx_q ? data_q : byte_q;
                    dv_d     = rx_q;
                    err_d    = !rx_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLEANUP: begin
                // Wait for the line to return high so a held-low line is not read as 0x00 frames.
                if (rx_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
            active_q  <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            err_q     <= err_d;
            active_q  <= active_d;
            rx_meta_q <= i_Rx_Serial;
            rx_q      <= rx_meta_q;
        end
    end

    assign o_Rx_DV        = dv_q;
    assign o_Rx_Byte      = byte_q;
    assign o_Rx_Active    = active_q;
    assign o_Rx_Frame_Err = err_q;
endmodule
